mac_lane_array: RTL and testbench
=================================

Name: mac_lane_array

Overview:
- Parametrised successor of the single 8x8 multiply-add cell in the convolution datapath.
- Multiplies LANES signed activation/weight pairs per beat, reduces them through a registered adder tree and accumulates over a multi-beat kernel window.
- Adds a per-window bias and emits one result per window over a valid/ready handshake.
- Sits between the window/line-buffer feeder and the requantise/activation stage.

Parameters:
- DATA_W, 8, width of each signed activation and weight element
- LANES, 9, multiply lanes per beat (3x3 kernel in one beat)
- ACC_W, 32, accumulator, bias and result width, signed

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_act  in  LANES*DATA_W  packed signed activations; lane i at bits [i*DATA_W +: DATA_W]
- in_wgt  in  LANES*DATA_W  packed signed weights, same packing
- in_last  in  1  beat is the final beat of the current window
- bias  in  ACC_W  signed bias, sampled on the first beat of a window
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed window result
- out_ovf  out  1  sticky overflow flag for the window

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ovf=0.
  - All pipeline valids and the accumulator cleared; first-beat flag set.
  - in_ready=1 in the cycle after reset.
  - Reset mid-window discards the partial sum; no result is emitted.
- Stall:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every pipeline stage and the accumulator hold their values.
  - A beat is accepted only when in_valid & in_ready.
- Pipeline (beat accepted at edge t):
  - Stage 1 (t+1): LANES signed products, each 2*DATA_W wide, registered together with last/first flags.
  - Stage 2 (t+2): adder-tree sum, width 2*DATA_W+clog2(LANES), registered.
  - Stage 3 (t+3): tree sum sign-extended to ACC_W, then:
    - first beat: acc = bias + sum;
    - otherwise: acc = acc + sum.
  - Fixed latency 3 cycles from the last beat's acceptance to out_valid.
- First-beat tracking:
  - The first flag is set after reset and after each beat carrying in_last.
  - bias is captured into the stage-1 register on a first beat.
- FSM, states ACCUM and HOLD:
  - ACCUM -> HOLD when a stage-3 beat with last completes. Same edge: out_data=acc result, out_valid=1.
  - HOLD -> ACCUM when out_ready=1.
  - HOLD with out_ready=0 stalls; out_data and out_valid are stable.
  - In HOLD with out_ready=1 and a new last beat in stage 3 on the same edge: the new result replaces the old; out_valid stays 1 with no bubble.
- Single-beat window (in_last on the first beat): result = bias + sum.
- Overflow:
  - out_ovf is set if any accumulate in the window overflows signed ACC_W.
  - Cleared at the next window's first beat.
  - Without saturation, arithmetic wraps modulo 2^ACC_W.
- Back-to-back windows are supported at full throughput, one beat per cycle.

Optional Feature:
- Macro MAC_LANE_SAT_EN.
- Defined: on signed overflow, the accumulator clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) and holds that bound for the rest of the window. out_ovf is still reported.
- Undefined: two's-complement wrap. out_ovf is still reported.

Decomposition:
- Package cnn_mac_pkg holds:
  - default width constants DATA_W_DEF and ACC_W_DEF;
  - function for tree width (2*DATA_W+clog2(LANES));
  - saturation bound constants derived from ACC_W;
  - FSM state enum (ACCUM, HOLD).
- One sub-module mac_adder_tree: combinational reduction of LANES signed products, parametrised on lane count and product width.

Test Plan:
- Single beat: LANES=9, all act=2, wgt=3, bias=10, in_last=1 -> out_data=64 exactly 3 cycles after accept, out_ovf=0.
- Three-beat window: per-beat sums 100, -50, 7, bias=-1 -> out_data=56; out_valid only after the third beat.
- Backpressure: hold out_ready=0 for 5 cycles with beats pending -> in_ready=0, out_data stable, no beats lost. Release -> the following window result is correct.
- Extremes: all act=-128, wgt=-128 over 2 beats, bias=0 -> out_data=294912, out_ovf=0. Then bias=0x7FFFFFF0 with one beat of sum 16384 -> wrap, or clamp to 0x7FFFFFFF with MAC_LANE_SAT_EN; out_ovf=1 in both builds.
- Reset in the middle of a two-beat window, then a fresh one-beat window: act=1, wgt=1, bias=0 -> out_data=9, with no stale partial sum.
- Back-to-back single-beat windows every cycle with out_ready=1 -> one result per cycle, in order, no bubbles.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// -----------------------------------------------------------------------------
// cnn_mac_pkg
// Shared definitions for the convolution MAC lane array:
//   - default element / accumulator widths
//   - adder-tree output width helper
//   - saturation bounds for the default accumulator width
//   - result FSM state encoding
// -----------------------------------------------------------------------------
package cnn_mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LANES_DEF  = 9;
    localparam int ACC_W_DEF  = 32;

    // Width needed to sum `lanes` signed products of two `data_w` operands
    // without loss.
    function automatic int tree_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    // Signed clamp bounds for the default accumulator width.
    localparam logic signed [ACC_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,   // accumulating, no result pending
        HOLD  = 1'b1    // result presented on out_data, waiting for out_ready
    } mac_state_e;

endpackage : cnn_mac_pkg

// File: rtl/mac_adder_tree.sv
// -----------------------------------------------------------------------------
// mac_adder_tree
// Combinational signed reduction of LANES products into one sum.
//   prod_i : LANES packed signed products, lane i at [i*PROD_W +: PROD_W]
//   sum_o  : signed sum, wide enough that it can never overflow
// -----------------------------------------------------------------------------
module mac_adder_tree #(
    parameter int LANES  = 9,
    parameter int PROD_W = 16,
    parameter int SUM_W  = PROD_W + $clog2(LANES)
) (
    input  logic [LANES*PROD_W-1:0] prod_i,
    output logic signed [SUM_W-1:0] sum_o
);

    always_comb begin
        // NOTE: blocking '=' is right inside always_comb: each iteration must
        // see the running sum from the previous one. Clocked state uses '<='.
        sum_o = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_o = sum_o + SUM_W'($signed(prod_i[i*PROD_W +: PROD_W]));
        end
    end

endmodule : mac_adder_tree

// File: rtl/mac_lane_array.sv
// -----------------------------------------------------------------------------
// mac_lane_array
// LANES-wide signed multiply / adder-tree / accumulate datapath. Each accepted
// beat multiplies LANES activation/weight pairs; beats are summed over a window
// terminated by in_last, the window's bias is added and one result is emitted
// over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_act, in_wgt      packed signed lanes, lane i at [i*DATA_W +: DATA_W]
//   in_last             final beat of the window
//   bias                window bias, taken from the window's first beat
//   out_valid/out_ready result handshake
//   out_data            signed window result
//   out_ovf             any accumulate in this window overflowed ACC_W
//
// Pipeline: input register (edge t), products (t+1), tree sum (t+2),
// accumulator and result (t+3). The whole pipe freezes while a result is held
// and not accepted.
//
// Build option: define MAC_LANE_SAT_EN to clamp the accumulator on signed
// overflow (and keep the bound for the rest of the window) instead of wrapping.
// -----------------------------------------------------------------------------
module mac_lane_array
    import cnn_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_act,
    input  logic [LANES*DATA_W-1:0] in_wgt,
    input  logic                    in_last,
    input  logic [ACC_W-1:0]        bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = tree_w(DATA_W, LANES);

`ifdef MAC_LANE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // ---------------------------------------------------------------- control
    mac_state_e state_q, state_d;
    logic       stall;
    logic       accept;
    logic       s3_done;
    logic       first_q;

    // ---------------------------------------------------------------- stage 0
    logic                    s0_valid_q;
    logic [LANES*DATA_W-1:0] s0_act_q, s0_wgt_q;
    logic                    s0_last_q, s0_first_q;
    logic signed [ACC_W-1:0] s0_bias_q;

    // ---------------------------------------------------------------- stage 1
    logic                    s1_valid_q;
    logic [LANES*PROD_W-1:0] prod_d, s1_prod_q;
    logic                    s1_last_q, s1_first_q;
    logic signed [ACC_W-1:0] s1_bias_q;

    // ---------------------------------------------------------------- stage 2
    logic                    s2_valid_q;
    logic signed [SUM_W-1:0] tree_sum, s2_sum_q;
    logic                    s2_last_q, s2_first_q;
    logic signed [ACC_W-1:0] s2_bias_q;

    // ---------------------------------------------------------------- stage 3
    logic signed [ACC_W-1:0] sum_ext, acc_base, acc_raw, acc_d, acc_q;
    logic                    add_ovf, win_ovf_d, win_ovf_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic                    out_ovf_q;

    assign stall    = (state_q == HOLD) & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;
    assign s3_done  = s2_valid_q & s2_last_q & ~stall;

    // Per-lane signed multiply; both operands signed so the product is
    // sign-extended to the full PROD_W result.
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic signed [DATA_W-1:0] act, wgt;
        assign act = s0_act_q[i*DATA_W +: DATA_W];
        assign wgt = s0_wgt_q[i*DATA_W +: DATA_W];
        assign prod_d[i*PROD_W +: PROD_W] = act * wgt;
    end

    mac_adder_tree #(
        .LANES  (LANES),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_tree (
        .prod_i (s1_prod_q),
        .sum_o  (tree_sum)
    );

    // Accumulate step. A first beat restarts from the bias, so a partial sum
    // or overflow from the previous window never leaks into this one.
    always_comb begin
        sum_ext   = ACC_W'(s2_sum_q);
        acc_base  = s2_first_q ? s2_bias_q : acc_q;
        acc_raw   = acc_base + sum_ext;
        // Signed overflow: operands agree in sign, result does not.
        add_ovf   = (acc_base[ACC_W-1] == sum_ext[ACC_W-1]) &&
                    (acc_raw[ACC_W-1] != acc_base[ACC_W-1]);
        win_ovf_d = (s2_first_q ? 1'b0 : win_ovf_q) | add_ovf;
        acc_d     = acc_raw;
`ifdef MAC_LANE_SAT_EN
        // Once clamped, the bound is kept until the window ends.
        if (!s2_first_q && win_ovf_q) begin
            acc_d = acc_q;
        end else if (add_ovf) begin
            acc_d = acc_base[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Valids, first-beat flag, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            first_q    <= 1'b1;
            acc_q      <= '0;
            win_ovf_q  <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (!stall) begin
            s0_valid_q <= accept;
            s1_valid_q <= s0_valid_q;
            s2_valid_q <= s1_valid_q;
            if (accept) begin
                first_q <= in_last;
            end
            if (s2_valid_q) begin
                acc_q     <= acc_d;
                win_ovf_q <= win_ovf_d;
                if (s2_last_q) begin
                    out_data_q <= acc_d;
                    out_ovf_q  <= win_ovf_d;
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only ever consumed
    // when the matching valid bit (which is reset) says they hold a beat.
    always_ff @(posedge clk) begin
        if (!stall) begin
            if (accept) begin
                s0_act_q   <= in_act;
                s0_wgt_q   <= in_wgt;
                s0_last_q  <= in_last;
                s0_first_q <= first_q;
                if (first_q) begin
                    s0_bias_q <= bias;
                end
            end
            if (s0_valid_q) begin
                s1_prod_q  <= prod_d;
                s1_last_q  <= s0_last_q;
                s1_first_q <= s0_first_q;
                s1_bias_q  <= s0_bias_q;
            end
            if (s1_valid_q) begin
                s2_sum_q   <= tree_sum;
                s2_last_q  <= s1_last_q;
                s2_first_q <= s1_first_q;
                s2_bias_q  <= s1_bias_q;
            end
        end
    end

    // Result FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Result FSM: next state. A new result arriving while the old one is
    // being accepted keeps HOLD so out_valid has no bubble.
    always_comb begin
        // NOTE: assign the default before the case so every path drives
        // state_d; a missing assignment would infer a latch.
        state_d = state_q;
        case (state_q)
            ACCUM: if (s3_done) state_d = HOLD;
            HOLD:  if (out_ready) state_d = s3_done ? HOLD : ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule : mac_lane_array

// File: tb/tb_mac_lane_array.sv
// -----------------------------------------------------------------------------
// tb_mac_lane_array
// Directed bench for mac_lane_array (LANES=9, DATA_W=8, ACC_W=32). Single-beat
// windows come from a vector table; multi-beat windows, backpressure, reset
// mid-window and back-to-back streaming are hand-written sequences. Expected
// results follow the MAC_LANE_SAT_EN build option.
// -----------------------------------------------------------------------------
module tb_mac_lane_array;

    localparam int LANES  = 9;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int VW     = LANES * DATA_W;

`ifdef MAC_LANE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    in_act;
    logic [VW-1:0]    in_wgt;
    logic             in_last;
    logic [ACC_W-1:0] bias;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mac_lane_array #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a0;       // lane i activation = a0 + i*da
        int          da;
        int          w0;       // lane i weight     = w0 + i*dw
        int          dw;
        bit          one;      // only lane 0 populated
        logic [31:0] bias;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    function automatic logic [VW-1:0] ramp(input int a0, input int d);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = 8'(a0 + i * d);
        return v;
    endfunction

    function automatic logic [VW-1:0] lane0(input int a);
        logic [VW-1:0] v;
        v = '0;
        v[DATA_W-1:0] = 8'(a);
        return v;
    endfunction

    // Present one beat from the next falling edge and hold it until accepted.
    // Returns at the accepting rising edge + 1.
    task automatic beat(input logic [VW-1:0] a, input logic [VW-1:0] w,
                        input logic last, input logic [31:0] b);
        int guard;
        @(negedge clk);
        in_act = a; in_wgt = w; in_last = last; bias = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("beat_accept_timeout", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges after an accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    initial begin
        int lat;
        int guard;
        logic seen;
        logic [31:0] held;
        logic [31:0] got[$];
        logic [31:0] bp_exp[4];

        vecs[0]  = '{2, 0, 3, 0, 1'b0, 10, 64, 64, 1'b0};
        vecs[1]  = '{-128, 0, 127, 0, 1'b0, 0, -146304, -146304, 1'b0};
        vecs[2]  = '{-1, 0, 1, 0, 1'b0, 5, -4, -4, 1'b0};
        vecs[3]  = '{1, 1, 1, 0, 1'b0, -45, 0, 0, 1'b0};
        vecs[4]  = '{-4, 1, -4, 1, 1'b0, 100, 160, 160, 1'b0};
        vecs[5]  = '{127, 0, 127, 0, 1'b0, -1, 145160, 145160, 1'b0};
        vecs[6]  = '{0, 0, 5, 0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[7]  = '{10, -3, 1, 1, 1'b0, 0, -270, -270, 1'b0};
        vecs[8]  = '{-128, 0, -128, 0, 1'b1, 32'h7FFF_FFF0, 32'h8000_3FF0, 32'h7FFF_FFFF, 1'b1};
        vecs[9]  = '{-1, 0, 1, 0, 1'b0, 32'h8000_0000, 32'h7FFF_FFF7, 32'h8000_0000, 1'b1};
        vecs[10] = '{1, 0, 1, 0, 1'b0, 0, 9, 9, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_act = '0; in_wgt = '0;
        bias = '0; out_ready = 1'b1;

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", {31'b0, out_ovf}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 1);

        // ---------------- single-beat windows from the table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].one)
                beat(lane0(vecs[i].a0), lane0(vecs[i].w0), 1'b1, vecs[i].bias);
            else
                beat(ramp(vecs[i].a0, vecs[i].da), ramp(vecs[i].w0, vecs[i].dw), 1'b1, vecs[i].bias);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_data", i), out_data, SAT ? vecs[i].exp_sat : vecs[i].exp_wrap);
            check($sformatf("vec%0d_ovf", i), {31'b0, out_ovf}, {31'b0, vecs[i].exp_ovf});
        end

        // ---------------- three-beat window: 100, -50, 7 with bias -1
        beat(lane0(10), lane0(10), 1'b0, -1);
        check("w3_no_valid_b1", {31'b0, out_valid}, 0);
        beat(lane0(5), lane0(-10), 1'b0, 0);
        check("w3_no_valid_b2", {31'b0, out_valid}, 0);
        beat(lane0(7), lane0(1), 1'b1, 0);
        wait_result(lat);
        check("w3_latency", lat, 3);
        check("w3_data", out_data, 56);
        check("w3_ovf", {31'b0, out_ovf}, 0);

        // ---------------- extremes: two beats of 9 x 16384
        beat(ramp(-128, 0), ramp(-128, 0), 1'b0, 0);
        beat(ramp(-128, 0), ramp(-128, 0), 1'b1, 0);
        wait_result(lat);
        check("ext_data", out_data, 294912);
        check("ext_ovf", {31'b0, out_ovf}, 0);

        // overflow on beat 1, pulled back on beat 2: clamp must hold
        beat(lane0(-128), lane0(-128), 1'b0, 32'h7FFF_FFF0);
        beat(lane0(-128), lane0(127), 1'b1, 0);
        wait_result(lat);
        check("ovf_hold_data", out_data, SAT ? 32'h7FFF_FFFF : 32'h8000_0070);
        check("ovf_hold_ovf", {31'b0, out_ovf}, 1);

        // ---------------- reset in the middle of a window
        beat(ramp(50, 0), ramp(50, 0), 1'b0, 1000);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("midrst_no_result", {31'b0, seen}, 0);
        beat(ramp(1, 0), ramp(1, 0), 1'b1, 0);
        wait_result(lat);
        check("midrst_latency", lat, 3);
        check("midrst_data", out_data, 9);
        check("midrst_ovf", {31'b0, out_ovf}, 0);

        // ---------------- backpressure
        bp_exp[0] = 64; bp_exp[1] = 118; bp_exp[2] = -18; bp_exp[3] = -50;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                beat(ramp(2, 0), ramp(3, 0), 1'b1, 10);
                beat(ramp(1, 0), ramp(1, 0), 1'b0, 100);
                beat(ramp(1, 0), ramp(1, 0), 1'b1, 0);
                beat(ramp(-1, 0), ramp(2, 0), 1'b1, 0);
                beat(ramp(3, 0), ramp(-2, 0), 1'b1, 4);
            end
            begin
                guard = 0;
                while (!out_valid && guard < 30) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                check("bp_first_valid", {31'b0, out_valid}, 1);
                held = out_data;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("bp_in_ready_low", {31'b0, in_ready}, 0);
                    check("bp_data_stable", out_data, held);
                end
                out_ready = 1'b1;
                guard = 0;
                while (got.size() < 4 && guard < 30) begin
                    if (out_valid) got.push_back(out_data);
                    @(posedge clk);
                    #1;
                    guard++;
                end
            end
        join
        check("bp_result_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            check($sformatf("bp_result%0d", i), got[i], bp_exp[i]);

        // ---------------- back-to-back single-beat windows
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    beat(ramp(k, 0), ramp(1, 0), 1'b1, k);
            end
            begin
                guard = 0;
                while (!out_valid && guard < 30) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                for (int k = 1; k <= 6; k++) begin
                    check($sformatf("b2b%0d_valid", k), {31'b0, out_valid}, 1);
                    check($sformatf("b2b%0d_data", k), out_data, 10 * k);
                    @(posedge clk);
                    #1;
                end
            end
        join

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mac_lane_array
